// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-register command sequencer.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] OP_SHR = 2'd0;
  localparam logic [1:0] OP_SHL = 2'd1;
  localparam logic [1:0] OP_CLR = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bidir_shift_reg.sv
// Bidirectional shift register datapath with a registered serial-out bit.
module bidir_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             dir,
  input  logic             sin,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  // sout is zero on any cycle that did not shift, so it reads 0 when not valid.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q    <= '0;
      sout <= 1'b0;
    end else if (clear) begin
      q    <= '0;
      sout <= 1'b0;
    end else if (en) begin
      if (dir) begin
        q    <= {q[WIDTH-2:0], sin};
        sout <= q[WIDTH-1];
      end else begin
        q    <= {sin, q[WIDTH-1:1]};
        sout <= q[0];
      end
    end else begin
      sout <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer: accepts one shift/clear command and drives the shift register.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_bits,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic             busy,
  output logic             done
);

  state_t             state, state_nxt;
  logic [1:0]         op_r;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   bits_r;
  logic [CNT_W-1:0]   len_sat;
  logic               accept;
  logic               is_shift_op;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign accept      = cmd_valid && cmd_ready;
  assign is_shift_op = (cmd_op == OP_SHR) || (cmd_op == OP_SHL);

  // Saturating here keeps the down-counter from ever wrapping.
  always_comb begin
    len_sat = cmd_len;
    if (cmd_len > CNT_W'(WIDTH)) len_sat = CNT_W'(WIDTH);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (is_shift_op && len_sat != '0) ? SHIFT : DONE;
      SHIFT: if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt holds remaining shifts; bits_r is consumed LSB first by shifting it down.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state         <= IDLE;
      op_r          <= OP_SHR;
      cnt           <= '0;
      bits_r        <= '0;
      ser_out_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      ser_out_valid <= (state == SHIFT);
      if (accept) begin
        op_r   <= cmd_op;
        cnt    <= len_sat;
        bits_r <= cmd_bits;
      end else if (state == SHIFT) begin
        cnt    <= cnt - CNT_W'(1);
        bits_r <= bits_r >> 1;
      end
    end
  end

  bidir_shift_reg #(.WIDTH(WIDTH)) u_sreg (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (state == SHIFT),
    .dir   (op_r == OP_SHL),
    .sin   (bits_r[0]),
    .clear (accept && cmd_op == OP_CLR),
    .q     (q),
    .sout  (ser_out)
  );

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command-driven sequencer for a bidirectional shift-register datapath.
- Accepts one command at a time over a valid/ready handshake: shift right, shift left, or clear.
- Drives the embedded shift register for the commanded number of cycles, one serial bit per cycle taken from a command payload.
- Reports completion with a one-cycle done pulse and the bit shifted out on each cycle.
- Sits between a host/CSR block and the serial datapath, replacing hand-toggled direction and serial-in lines.

Parameters:
WIDTH, 4, shift register width in bits (≥2)
CNT_W, $clog2(WIDTH+1), width of the shift-length field

Ports:
clk  in  1  rising-edge clock
clr_n  in  1  reset; asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  2  0=SHIFT_RIGHT, 1=SHIFT_LEFT, 2=CLEAR, 3=reserved (treated as no-op)
cmd_len  in  CNT_W  number of shift cycles
cmd_bits  in  WIDTH  serial-in bits, consumed LSB first
q  out  WIDTH  shift register contents
ser_out  out  1  bit shifted out on the current shift cycle
ser_out_valid  out  1  ser_out is meaningful
busy  out  1  command in progress (SHIFT or DONE)
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (clr_n=0, asynchronous): state=IDLE, q=0, counter=0, latched bits=0, cmd_ready=1, busy=0, done=0, ser_out=0, ser_out_valid=0.
- Reset asserted mid-command aborts the command immediately and applies the reset values; no done is issued.
- Handshake: a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
- cmd_ready=1 only in IDLE. cmd_valid held high while busy is ignored. No command queueing.
- The latched cmd_op, cmd_len and cmd_bits are used for the whole command; input changes after acceptance have no effect.

State machine: IDLE → SHIFT → DONE → IDLE.
- IDLE: on accept, latch op, bits and len. The length is saturated to WIDTH when cmd_len>WIDTH.
  - SHIFT_RIGHT/SHIFT_LEFT with len≥1: go to SHIFT.
  - len=0, CLEAR, or reserved op: go straight to DONE.
  - CLEAR sets q=0 on the accept edge.
- SHIFT: one shift per cycle for exactly len cycles. Bit k of the latched bits is used on shift k (k=0..len-1).
  - Right: q ← {bit_k, q[WIDTH-1:1]}; ser_out = old q[0].
  - Left: q ← {q[WIDTH-2:0], bit_k}; ser_out = old q[WIDTH-1].
  - ser_out and ser_out_valid are registered alongside q, so they update on the same edge as the shift and reflect the bit just shifted out.
  - After the len-th shift, go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, cmd_ready=0. Next cycle go to IDLE.
- q holds its value in IDLE and DONE.
- Latency: accept edge + len shift cycles + 1 DONE cycle. A new command can be accepted on the cycle after done.
- ser_out_valid=1 on the cycles following each shift edge (len cycles total); otherwise 0, and ser_out holds 0.
- Counter width is CNT_W. The counter never wraps, because len is saturated at acceptance.

Decomposition:
- Package shift_seq_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - op constants OP_SHR=2'd0, OP_SHL=2'd1, OP_CLR=2'd2;
  - default WIDTH.
- Sub-module bidir_shift_reg (WIDTH):
  - ports: clk, clr_n, en, dir, sin, clear, q, sout;
  - it is the pure datapath; the FSM, counter and bit selection stay in shift_seq_ctrl.

Test Plan (WIDTH=4):
1. Reset: hold clr_n=0, then release → q=0000, cmd_ready=1, busy=0, done=0. Assert clr_n=0 while in SHIFT → q=0000 at once and no done.
2. SHIFT_RIGHT, len=4, bits=1011, from q=0000 → q sequence 1000, 1100, 0110, 1011; ser_out 0,0,0,0; done on cycle 5 after accept.
3. SHIFT_LEFT, len=4, bits=1011, from q=1011 → q sequence 0111, 1111, 1110, 1101; ser_out 1,0,1,1; done asserted 1 cycle.
4. SHIFT_RIGHT, len=7 (saturates to 4), bits=0000, from q=1101 → exactly 4 shifts, q=0000, ser_out 1,0,1,1.
5. len=0 shift → no q change, done the cycle after accept. CLEAR from q=1101 → q=0000 on the accept edge, then done.
6. cmd_valid held high during busy with different op/bits → ignored, q unaffected. Back-to-back commands accepted the cycle after done.
